cc_player_collision_manager: RTL and testbench

Registered, parametrised collision manager for the RoadFighter game datapath. Each game tick it compares the player row against the obstacle row, merges both onto a display row, decrements a lives counter on overlap, and holds an invulnerability (grace) window after every hit. It latches game-over until a restart request. It sits between the player/obstacle row generators and the LED-matrix display driver.

---
 rtl/cc_player_collision_manager.sv | 120 ++++++++++++
 tb/tb_cc_player_collision_manager.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/cc_player_collision_manager.sv
// Collision manager: merges player/obstacle rows, counts hits, grace window, game-over latch.
// Optional CC_PLAYER_COLLISION_BLINK_EN makes the player blink on alternate GRACE ticks.
module cc_player_collision_manager #(
  parameter int DATAWIDTH   = 8,
  parameter int LIVES       = 3,
  parameter int LIVESWIDTH  = 2,
  parameter int GRACE_TICKS = 4,
  parameter int GRACEWIDTH  = 3
) (
  input  logic                  CC_PLAYER_COLLISION_CLOCK_50,
  input  logic                  CC_PLAYER_COLLISION_RESET_InHigh,
  input  logic                  CC_PLAYER_COLLISION_Tick_In,
  input  logic                  CC_PLAYER_COLLISION_Start_In,
  input  logic [DATAWIDTH-1:0]  CC_PLAYER_COLLISION_Player_InBus,
  input  logic [DATAWIDTH-1:0]  CC_PLAYER_COLLISION_Obstacle_InBus,
  output logic [DATAWIDTH-1:0]  CC_PLAYER_COLLISION_Data_OutBus,
  output logic                  CC_PLAYER_COLLISION_Hit_Out,
  output logic [LIVESWIDTH-1:0] CC_PLAYER_COLLISION_Lives_OutBus,
  output logic                  CC_PLAYER_COLLISION_Grace_Out,
  output logic                  CC_PLAYER_COLLISION_Lost_OutLow
);

  // state    | meaning
  // PLAY     | normal play, overlaps are counted as hits
  // GRACE    | invulnerable after a non-fatal hit, graceCount ticks remaining
  // GAMEOVER | lives exhausted, outputs frozen until Start

  typedef enum logic [1:0] {PLAY, GRACE, GAMEOVER} stateType;

  localparam logic [LIVESWIDTH-1:0] LIVES_INIT = LIVES[LIVESWIDTH-1:0];
  localparam logic [LIVESWIDTH-1:0] LIVES_ONE  = LIVESWIDTH'(1);
  localparam logic [GRACEWIDTH-1:0] GRACE_INIT = GRACE_TICKS[GRACEWIDTH-1:0];
  localparam logic [GRACEWIDTH-1:0] GRACE_ONE  = GRACEWIDTH'(1);

  stateType              state;
  logic [GRACEWIDTH-1:0] graceCount;
  logic                  overlap;
  logic [DATAWIDTH-1:0]  mergedRow;
  logic [DATAWIDTH-1:0]  graceRow;

  assign overlap   = |(CC_PLAYER_COLLISION_Player_InBus & CC_PLAYER_COLLISION_Obstacle_InBus);
  assign mergedRow = CC_PLAYER_COLLISION_Player_InBus | CC_PLAYER_COLLISION_Obstacle_InBus;

`ifdef CC_PLAYER_COLLISION_BLINK_EN
  logic blinkPhase;

  assign graceRow = blinkPhase ? CC_PLAYER_COLLISION_Obstacle_InBus : mergedRow;

  // Phase is cleared on every GRACE entry so each grace window starts with the player visible.
  always_ff @(posedge CC_PLAYER_COLLISION_CLOCK_50) begin
    if (CC_PLAYER_COLLISION_RESET_InHigh) begin
      blinkPhase <= 1'b0;
    end else if (state == PLAY && CC_PLAYER_COLLISION_Tick_In && overlap) begin
      blinkPhase <= 1'b0;
    end else if (state == GRACE && CC_PLAYER_COLLISION_Tick_In) begin
      blinkPhase <= ~blinkPhase;
    end
  end
`else
  assign graceRow = mergedRow;
`endif

  always_ff @(posedge CC_PLAYER_COLLISION_CLOCK_50) begin
    if (CC_PLAYER_COLLISION_RESET_InHigh) begin
      state                            <= PLAY;
      graceCount                       <= '0;
      CC_PLAYER_COLLISION_Data_OutBus  <= '0;
      CC_PLAYER_COLLISION_Hit_Out      <= 1'b0;
      CC_PLAYER_COLLISION_Lives_OutBus <= LIVES_INIT;
      CC_PLAYER_COLLISION_Grace_Out    <= 1'b0;
      CC_PLAYER_COLLISION_Lost_OutLow  <= 1'b1;
    end else begin
      CC_PLAYER_COLLISION_Hit_Out <= 1'b0;
      case (state)
        PLAY: begin
          if (CC_PLAYER_COLLISION_Tick_In) begin
            CC_PLAYER_COLLISION_Data_OutBus <= mergedRow;
            if (overlap) begin
              CC_PLAYER_COLLISION_Hit_Out <= 1'b1;
              if (CC_PLAYER_COLLISION_Lives_OutBus > LIVES_ONE) begin
                CC_PLAYER_COLLISION_Lives_OutBus <= CC_PLAYER_COLLISION_Lives_OutBus - LIVES_ONE;
                graceCount                       <= GRACE_INIT;
                CC_PLAYER_COLLISION_Grace_Out    <= 1'b1;
                state                            <= GRACE;
              end else begin
                CC_PLAYER_COLLISION_Lives_OutBus <= '0;
                CC_PLAYER_COLLISION_Lost_OutLow  <= 1'b0;
                state                            <= GAMEOVER;
              end
            end
          end
        end
        GRACE: begin
          if (CC_PLAYER_COLLISION_Tick_In) begin
            CC_PLAYER_COLLISION_Data_OutBus <= graceRow;
            graceCount                      <= graceCount - GRACE_ONE;
            if (graceCount == GRACE_ONE) begin
              CC_PLAYER_COLLISION_Grace_Out <= 1'b0;
              state                         <= PLAY;
            end
          end
        end
        GAMEOVER: begin
          // Start takes precedence over a coincident tick; that tick is discarded.
          if (CC_PLAYER_COLLISION_Start_In) begin
            CC_PLAYER_COLLISION_Lives_OutBus <= LIVES_INIT;
            CC_PLAYER_COLLISION_Data_OutBus  <= '0;
            CC_PLAYER_COLLISION_Lost_OutLow  <= 1'b1;
            graceCount                       <= '0;
            state                            <= PLAY;
          end
        end
        default: begin
          state <= PLAY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cc_player_collision_manager.sv
// Bench for cc_player_collision_manager: directed plan steps, then random traffic vs a tick-level model.
module tb_cc_player_collision_manager;

  localparam int GRACE_TICKS = 4;
  localparam int LIVES       = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0;
  logic       start = 1'b0;
  logic [7:0] player = '0;
  logic [7:0] obstacle = '0;
  logic [7:0] dataOut;
  logic       hitOut;
  logic [1:0] livesOut;
  logic       graceOut;
  logic       lostOutLow;

  int checks = 0;
  int errors = 0;

  // Reference model state, expressed as game facts rather than FSM states.
  int  mLives;
  int  mImmuneLeft;
  bit  mGameOver;
  int  mData;
  bit  mHit;
  bit  mPhase;

  always #5 clk = ~clk;

  cc_player_collision_manager dut (
    .CC_PLAYER_COLLISION_CLOCK_50      (clk),
    .CC_PLAYER_COLLISION_RESET_InHigh  (rst),
    .CC_PLAYER_COLLISION_Tick_In       (tick),
    .CC_PLAYER_COLLISION_Start_In      (start),
    .CC_PLAYER_COLLISION_Player_InBus  (player),
    .CC_PLAYER_COLLISION_Obstacle_InBus(obstacle),
    .CC_PLAYER_COLLISION_Data_OutBus   (dataOut),
    .CC_PLAYER_COLLISION_Hit_Out       (hitOut),
    .CC_PLAYER_COLLISION_Lives_OutBus  (livesOut),
    .CC_PLAYER_COLLISION_Grace_Out     (graceOut),
    .CC_PLAYER_COLLISION_Lost_OutLow   (lostOutLow)
  );

  task automatic chk(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic modelStep(input bit r, input bit t, input bit s, input int p, input int o);
    mHit = 1'b0;
    if (r) begin
      mLives = LIVES; mImmuneLeft = 0; mGameOver = 1'b0; mData = 0; mPhase = 1'b0;
    end else if (mGameOver) begin
      if (s) begin
        mLives = LIVES; mImmuneLeft = 0; mGameOver = 1'b0; mData = 0;
      end
    end else if (t) begin
      if (mImmuneLeft > 0) begin
`ifdef CC_PLAYER_COLLISION_BLINK_EN
        mData = mPhase ? o : (p | o);
`else
        mData = p | o;
`endif
        mPhase = ~mPhase;
        mImmuneLeft--;
      end else begin
        mData = p | o;
        if ((p & o) != 0) begin
          mHit = 1'b1;
          mLives--;
          if (mLives == 0) mGameOver = 1'b1;
          else begin
            mImmuneLeft = GRACE_TICKS;
            mPhase = 1'b0;
          end
        end
      end
    end
  endtask

  task automatic checkAll();
    chk("data",  int'(dataOut),    mData);
    chk("hit",   int'(hitOut),     int'(mHit));
    chk("lives", int'(livesOut),   mLives);
    chk("grace", int'(graceOut),   int'(mImmuneLeft > 0));
    chk("lost",  int'(lostOutLow), int'(!mGameOver));
  endtask

  task automatic cycle(input bit r, input bit t, input bit s, input logic [7:0] p, input logic [7:0] o);
    rst = r; tick = t; start = s; player = p; obstacle = o;
    @(posedge clk);
    modelStep(r, t, s, int'(p), int'(o));
    #1;
    checkAll();
  endtask

  initial begin
    mLives = LIVES; mImmuneLeft = 0; mGameOver = 1'b0; mData = 0; mHit = 1'b0; mPhase = 1'b0;

    cycle(1, 0, 0, 8'h00, 8'h00);
    chk("reset_lives", int'(livesOut), 3);
    chk("reset_lost",  int'(lostOutLow), 1);

    cycle(0, 1, 0, 8'h10, 8'h01);
    chk("play_merge", int'(dataOut), 8'h11);

    cycle(0, 1, 0, 8'h10, 8'h30);
    chk("first_hit",   int'(hitOut), 1);
    chk("first_lives", int'(livesOut), 2);
    chk("first_grace", int'(graceOut), 1);
    chk("first_data",  int'(dataOut), 8'h30);

    cycle(0, 0, 0, 8'h10, 8'h10);
    chk("hit_one_cycle", int'(hitOut), 0);

    for (int i = 0; i < GRACE_TICKS; i++) begin
      cycle(0, 1, 1, 8'h10, 8'h10);
      chk("grace_immune", int'(livesOut), 2);
    end
    chk("grace_falls", int'(graceOut), 0);

    cycle(0, 1, 0, 8'h10, 8'h10);
    chk("second_hit",   int'(hitOut), 1);
    chk("second_lives", int'(livesOut), 1);

    for (int i = 0; i < GRACE_TICKS; i++) cycle(0, 1, 0, 8'h04, 8'h04);
    cycle(0, 1, 0, 8'h10, 8'h18);
    chk("fatal_lives", int'(livesOut), 0);
    chk("fatal_lost",  int'(lostOutLow), 0);
    chk("fatal_data",  int'(dataOut), 8'h18);

    cycle(0, 1, 0, 8'hff, 8'h00);
    cycle(0, 1, 0, 8'h01, 8'h01);
    chk("frozen_data", int'(dataOut), 8'h18);

    cycle(0, 1, 1, 8'h01, 8'h01);
    chk("restart_lives", int'(livesOut), 3);
    chk("restart_data",  int'(dataOut), 0);
    chk("restart_lost",  int'(lostOutLow), 1);
    chk("restart_hit",   int'(hitOut), 0);

    cycle(0, 1, 0, 8'h02, 8'h02);
    cycle(0, 1, 0, 8'h10, 8'h01);
`ifdef CC_PLAYER_COLLISION_BLINK_EN
    chk("blink_on", int'(dataOut), 8'h11);
    cycle(0, 1, 0, 8'h10, 8'h01);
    chk("blink_off", int'(dataOut), 8'h01);
`endif
    cycle(1, 1, 1, 8'h10, 8'h10);
    chk("midgrace_reset_grace", int'(graceOut), 0);
    chk("midgrace_reset_lives", int'(livesOut), 3);
    chk("midgrace_reset_data",  int'(dataOut), 0);

    for (int i = 0; i < 3000; i++) begin
      logic [7:0] p;
      logic [7:0] o;
      p = 8'(1 << $urandom_range(0, 7));
      o = 8'($urandom) & 8'($urandom);
      cycle($urandom_range(0, 99) == 0, $urandom_range(0, 1) == 1,
            $urandom_range(0, 7) == 0, p, o);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
